// File: rtl/mem_stage_param.sv
// Memory/stack stage: single-beat LOAD/STORE/PUSH/POP plus multi-beat
// CALL/RET/INT/RTI sequenced one memory beat per cycle over a shared word memory.
module mem_stage_param #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int ADDR_W = 10,
  parameter int FLAG_W = 3,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] rdata,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_out_valid,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_out_valid,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_err
);
  localparam int W     = PC_W / DATA_W;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [ADDR_W-1:0] SP_MAX = '1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(W - 1);

  localparam logic [3:0] OP_LOAD = 4'd1, OP_STORE = 4'd2, OP_PUSH = 4'd3,
                         OP_POP  = 4'd4, OP_CALL  = 4'd5, OP_RET  = 4'd6,
                         OP_INT  = 4'd7, OP_RTI   = 4'd8;

  typedef enum logic [2:0] {IDLE, PUSH_PC, PUSH_FLG, VEC_RD, POP_FLG, POP_PC} st_t;

  st_t               st_q, st_d, beat_st;
  logic [CNT_W-1:0]  cnt_q, cnt_d, idx;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [PC_W-1:0]   pco_q, pco_d, acc_q, acc_d, pc_q, pc_d, cur_pc;
  logic [FLAG_W-1:0] flo_q, flo_d, flg_q, flg_d, cur_flg;
  logic              vout_q, vout_d, pcv_q, pcv_d, flv_q, flv_d, irq_q, irq_d;
  logic              accept, do_push, do_pop, we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdat, push_word, pop_word;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  function automatic logic [PC_W-1:0] place(logic [PC_W-1:0] acc, logic [CNT_W-1:0] i,
                                            logic [DATA_W-1:0] w);
    int sh;
    sh = DATA_W * int'(i);
    return (acc & ~(PC_W'({DATA_W{1'b1}}) << sh)) | (PC_W'(w) << sh);
  endfunction

  assign accept   = valid_in && (st_q == IDLE);
  // A pop at the top of the stack yields zero rather than wrapping to mem[0].
  assign pop_word = (sp_q == SP_MAX) ? '0 : mem_q[sp_q + ADDR_W'(1)];

  always_comb begin
    st_d = st_q; cnt_d = cnt_q; sp_d = sp_q; err_d = err_q;
    rdata_d = rdata_q; pco_d = pco_q; flo_d = flo_q;
    vout_d = 1'b0; pcv_d = 1'b0; flv_d = 1'b0;
    acc_d = acc_q; pc_d = pc_q; flg_d = flg_q; irq_d = irq_q;
    we = 1'b0; waddr = '0; wdat = '0;
    do_push = 1'b0; do_pop = 1'b0; push_word = '0;
    beat_st = st_q; idx = cnt_q; cur_pc = pc_q; cur_flg = flg_q;
    if (accept) begin
      pc_d = pc_in; flg_d = flags_in; cur_pc = pc_in; cur_flg = flags_in;
      acc_d = '0; idx = '0; beat_st = IDLE;
      case (op)
        OP_LOAD:  begin rdata_d = mem_q[addr]; vout_d = 1'b1; end
        OP_STORE: begin we = 1'b1; waddr = addr; wdat = wdata; vout_d = 1'b1; end
        OP_PUSH:  begin do_push = 1'b1; push_word = wdata; vout_d = 1'b1; end
        OP_POP:   begin do_pop = 1'b1; rdata_d = pop_word; vout_d = 1'b1; end
        OP_CALL:  begin irq_d = 1'b0; beat_st = PUSH_PC; end
        OP_INT:   begin irq_d = 1'b1; beat_st = PUSH_PC; end
        OP_RET:   begin irq_d = 1'b0; beat_st = POP_PC; end
        OP_RTI:   begin irq_d = 1'b1; beat_st = POP_FLG; end
        default:  vout_d = 1'b1;
      endcase
    end
    // The accepting edge already performs the first beat of a multi-beat op.
    case (beat_st)
      PUSH_PC: begin
        do_push   = 1'b1;
        push_word = DATA_W'(cur_pc >> (DATA_W * (W - 1 - int'(idx))));
        cnt_d     = '0;
        if (idx != LAST) begin st_d = PUSH_PC; cnt_d = idx + CNT_W'(1); end
        else if (irq_d)   st_d = PUSH_FLG;
        else begin        st_d = IDLE; vout_d = 1'b1; end
      end
      PUSH_FLG: begin
        do_push   = 1'b1;
        push_word = DATA_W'(cur_flg);
        st_d = VEC_RD; cnt_d = '0;
      end
      VEC_RD: begin
        acc_d = place(acc_d, idx, mem_q[ADDR_W'(idx)]);
        cnt_d = '0;
        if (idx != LAST) begin st_d = VEC_RD; cnt_d = idx + CNT_W'(1); end
        else begin st_d = IDLE; pco_d = acc_d; pcv_d = 1'b1; vout_d = 1'b1; end
      end
      POP_FLG: begin
        do_pop = 1'b1;
        flg_d  = pop_word[FLAG_W-1:0];
        st_d = POP_PC; cnt_d = '0;
      end
      POP_PC: begin
        do_pop = 1'b1;
        acc_d  = place(acc_d, idx, pop_word);
        cnt_d  = '0;
        if (idx != LAST) begin st_d = POP_PC; cnt_d = idx + CNT_W'(1); end
        else begin
          st_d = IDLE; pco_d = acc_d; pcv_d = 1'b1; vout_d = 1'b1;
          if (irq_d) begin flo_d = flg_q; flv_d = 1'b1; end
        end
      end
      default: ;
    endcase
    if (do_push) begin
      if (sp_q == '0) err_d = 1'b1;
      else begin we = 1'b1; waddr = sp_q; wdat = push_word; sp_d = sp_q - ADDR_W'(1); end
    end
    if (do_pop) begin
      if (sp_q == SP_MAX) err_d = 1'b1;
      else sp_d = sp_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= IDLE; cnt_q <= '0; sp_q <= SP_INIT; err_q <= 1'b0;
      rdata_q <= '0; pco_q <= '0; flo_q <= '0;
      vout_q <= 1'b0; pcv_q <= 1'b0; flv_q <= 1'b0;
      acc_q <= '0; pc_q <= '0; flg_q <= '0; irq_q <= 1'b0;
    end else begin
      st_q <= st_d; cnt_q <= cnt_d; sp_q <= sp_d; err_q <= err_d;
      rdata_q <= rdata_d; pco_q <= pco_d; flo_q <= flo_d;
      vout_q <= vout_d; pcv_q <= pcv_d; flv_q <= flv_d;
      acc_q <= acc_d; pc_q <= pc_d; flg_q <= flg_d; irq_q <= irq_d;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdat;
  end

  assign ready_out       = (st_q == IDLE);
  assign valid_out       = vout_q;
  assign rdata           = rdata_q;
  assign pc_out          = pco_q;
  assign pc_out_valid    = pcv_q;
  assign flags_out       = flo_q;
  assign flags_out_valid = flv_q;
  assign sp_out          = sp_q;
  assign stack_err       = err_q;
endmodule

// File: tb/tb_mem_stage_param.sv
// Randomized + directed bench for mem_stage_param with a word-level stack model
// and a scoreboard drained by a monitor on every valid_out pulse.
module tb_mem_stage_param;
  localparam int DW = 16, PW = 32, AW = 10, FW = 3, W = PW / DW;

  logic clk = 1'b0, reset = 1'b0, valid_in = 1'b0;
  logic [3:0] op = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [PW-1:0] pc_in = '0;
  logic [FW-1:0] flags_in = '0;
  logic ready_out, valid_out, pc_out_valid, flags_out_valid, stack_err;
  logic [DW-1:0] rdata;
  logic [PW-1:0] pc_out;
  logic [FW-1:0] flags_out;
  logic [AW-1:0] sp_out;

  mem_stage_param dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out), .op(op),
    .addr(addr), .wdata(wdata), .pc_in(pc_in), .flags_in(flags_in),
    .valid_out(valid_out), .rdata(rdata), .pc_out(pc_out), .pc_out_valid(pc_out_valid),
    .flags_out(flags_out), .flags_out_valid(flags_out_valid), .sp_out(sp_out),
    .stack_err(stack_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rd; logic [PW-1:0] pc; logic pcv;
    logic [FW-1:0] fl; logic flv; logic [AW-1:0] sp; logic err;
  } exp_t;
  exp_t sb[$];

  int total = 0, passed = 0;
  logic [DW-1:0] mm [1024];
  int m_sp = 1023;
  logic m_err = 1'b0;
  logic [DW-1:0] m_rd = '0;
  logic [PW-1:0] m_pc = '0;
  logic [FW-1:0] m_fl = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  task automatic m_push(input logic [DW-1:0] w);
    if (m_sp == 0) m_err = 1'b1;
    else begin mm[m_sp] = w; m_sp--; end
  endtask

  task automatic m_pop(output logic [DW-1:0] w);
    if (m_sp == 1023) begin m_err = 1'b1; w = '0; end
    else begin m_sp++; w = mm[m_sp]; end
  endtask

  task automatic model(input logic [3:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [PW-1:0] p, input logic [FW-1:0] f,
                       output exp_t e, output int lo);
    logic [DW-1:0] w;
    logic [PW-1:0] v;
    logic pcv, flv;
    lo = 0; pcv = 1'b0; flv = 1'b0; v = '0;
    case (o)
      4'd1: m_rd = mm[a];
      4'd2: mm[a] = d;
      4'd3: m_push(d);
      4'd4: begin m_pop(w); m_rd = w; end
      4'd5: begin
        for (int i = W - 1; i >= 0; i--) m_push(p[i*DW +: DW]);
        lo = W - 1;
      end
      4'd6: begin
        for (int i = 0; i < W; i++) begin m_pop(w); v[i*DW +: DW] = w; end
        m_pc = v; pcv = 1'b1; lo = W - 1;
      end
      4'd7: begin
        for (int i = W - 1; i >= 0; i--) m_push(p[i*DW +: DW]);
        m_push(DW'(f));
        for (int i = 0; i < W; i++) v[i*DW +: DW] = mm[i];
        m_pc = v; pcv = 1'b1; lo = 2 * W;
      end
      4'd8: begin
        m_pop(w); m_fl = w[FW-1:0];
        for (int i = 0; i < W; i++) begin m_pop(w); v[i*DW +: DW] = w; end
        m_pc = v; pcv = 1'b1; flv = 1'b1; lo = W;
      end
      default: ;
    endcase
    e.rd = m_rd; e.pc = m_pc; e.pcv = pcv; e.fl = m_fl; e.flv = flv;
    e.sp = AW'(m_sp); e.err = m_err;
  endtask

  // Entered and left on a negedge; keeps valid_in high with garbage while busy.
  task automatic issue(input logic [3:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [PW-1:0] p, input logic [FW-1:0] f);
    exp_t e;
    int lo, n;
    model(o, a, d, p, f, e, lo);
    sb.push_back(e);
    valid_in = 1'b1; op = o; addr = a; wdata = d; pc_in = p; flags_in = f;
    @(posedge clk); @(negedge clk);
    op = 4'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
    pc_in = $urandom; flags_in = FW'($urandom);
    n = 0;
    while (!ready_out && n < 64) begin n++; @(negedge clk); end
    chk("ready_low_cycles", 64'(n), 64'(lo));
    chk("done_valid_out", 64'(valid_out), 64'd1);
    valid_in = 1'b0;
  endtask

  task automatic model_reset();
    m_sp = 1023; m_err = 1'b0; m_rd = '0; m_pc = '0; m_fl = '0;
    sb.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_sp", 64'(sp_out), 64'd1023);
    chk("rst_err", 64'(stack_err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_pc_out", 64'(pc_out), 64'd0);
    chk("rst_flags", 64'(flags_out), 64'd0);
    chk("rst_pcv_flv", {62'd0, pc_out_valid, flags_out_valid}, 64'd0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1 check_reset_vals();
    model_reset();
    @(negedge clk) reset = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && valid_out) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid_out actual=1 required=0 t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("rdata", 64'(rdata), 64'(e.rd));
        chk("pc_out", 64'(pc_out), 64'(e.pc));
        chk("pc_out_valid", 64'(pc_out_valid), 64'(e.pcv));
        chk("flags_out", 64'(flags_out), 64'(e.fl));
        chk("flags_out_valid", 64'(flags_out_valid), 64'(e.flv));
        chk("sp_out", 64'(sp_out), 64'(e.sp));
        chk("stack_err", 64'(stack_err), 64'(e.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] o;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 32; i++) issue(4'd2, AW'(i), DW'($urandom), '0, '0);

    // STORE then LOAD of the same address back to back
    issue(4'd2, 10'h010, 16'hBEEF, '0, '0);
    issue(4'd1, 10'h010, '0, '0, '0);
    chk("store_load_beef", 64'(rdata), 64'hBEEF);
    issue(4'd3, '0, 16'h1234, '0, '0);
    issue(4'd3, '0, 16'h5678, '0, '0);
    chk("sp_after_pushes", 64'(sp_out), 64'd1021);
    issue(4'd4, '0, '0, '0, '0);
    issue(4'd4, '0, '0, '0, '0);
    chk("pop_second", 64'(rdata), 64'h1234);
    issue(4'd5, '0, '0, 32'h0001_0040, '0);
    issue(4'd1, 10'd1023, '0, '0, '0);
    chk("call_mem1023", 64'(rdata), 64'h0001);
    issue(4'd1, 10'd1022, '0, '0, '0);
    chk("call_mem1022", 64'(rdata), 64'h0040);
    issue(4'd6, '0, '0, '0, '0);
    chk("ret_pc", 64'(pc_out), 64'h0001_0040);
    issue(4'd2, 10'd0, 16'h0100, '0, '0);
    issue(4'd2, 10'd1, 16'h0000, '0, '0);
    issue(4'd7, '0, '0, 32'h0000_0020, 3'b101);
    chk("int_vector", 64'(pc_out), 64'h0000_0100);
    chk("int_sp", 64'(sp_out), 64'd1020);
    issue(4'd8, '0, '0, '0, '0);
    chk("rti_flags", 64'(flags_out), 64'b101);
    chk("rti_pc", 64'(pc_out), 64'h0000_0020);
    issue(4'd4, '0, '0, '0, '0);
    chk("underflow_err", 64'(stack_err), 64'd1);
    issue(4'd0, '0, '0, '0, '0);
    issue(4'd3, '0, 16'h7777, '0, '0);
    chk("err_sticky", 64'(stack_err), 64'd1);

    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 15) o = 4'd1;
      else if (r < 30) o = 4'd2;
      else if (r < 50) o = 4'd3;
      else if (r < 65) o = 4'd4;
      else if (r < 73) o = 4'd5;
      else if (r < 81) o = 4'd6;
      else if (r < 87) o = 4'd7;
      else if (r < 93) o = 4'd8;
      else             o = 4'($urandom_range(9, 15));
      issue(o, AW'($urandom_range(0, 31)), DW'($urandom), $urandom, FW'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset while CALL is between its first and second beat
    do_reset();
    valid_in = 1'b1; op = 4'd5; pc_in = 32'h0001_0040;
    @(posedge clk); @(negedge clk);
    valid_in = 1'b0;
    chk("call_busy", 64'(ready_out), 64'd0);
    #1 reset = 1'b0;
    #1 chk("abort_ready", 64'(ready_out), 64'd1);
    chk("abort_sp", 64'(sp_out), 64'd1023);
    chk("abort_valid_out", 64'(valid_out), 64'd0);
    mm[1023] = 16'h0001;
    model_reset();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_valid", 64'(valid_out), 64'd0);
      @(negedge clk);
    end
    issue(4'd1, 10'd1023, '0, '0, '0);
    chk("abort_word_kept", 64'(rdata), 64'h0001);

    // Drive the stack all the way to the bottom and one beyond
    for (int i = 0; i < 1024; i++) issue(4'd3, '0, DW'(i), '0, '0);
    chk("overflow_sp", 64'(sp_out), 64'd0);
    chk("overflow_err", 64'(stack_err), 64'd1);
    issue(4'd5, '0, '0, 32'hCAFE_F00D, '0);
    for (int i = 0; i < 5; i++) issue(4'd4, '0, '0, '0, '0);
    issue(4'd1, 10'd0, '0, '0, '0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
